// File: rtl/sigma_delta_adc_pkg.sv
// Shared audio constants for the sigma-delta DAC/ADC pair: sample format and
// default EAR hysteresis thresholds.
package sigma_delta_adc_pkg;
  localparam int SAMPLE_W = 8;
  localparam logic [SAMPLE_W-1:0] SAMPLE_MID = 8'd128;
  localparam logic [SAMPLE_W-1:0] EAR_HI_THR_DEFAULT = 8'd140;
  localparam logic [SAMPLE_W-1:0] EAR_LO_THR_DEFAULT = 8'd116;
endpackage

// File: rtl/sync_2ff.sv
// One-bit two-flop synchroniser with synchronous reset to 0, for comparator,
// mic and joystick inputs arriving asynchronously to Clk.
module sync_2ff (
  input  logic Clk,
  input  logic Reset,
  input  logic d,
  output logic q
);
  logic s1_q, s1_d;
  logic s2_q, s2_d;

  always_comb begin
    s1_d = d;
    s2_d = s1_q;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q = s2_q;
endmodule

// File: rtl/sigma_delta_adc.sv
// First-order sigma-delta ADC front end: closes the comparator loop, decimates
// the bitstream with a boxcar ones-count and derives a hysteresis EAR bit.
module sigma_delta_adc
  import sigma_delta_adc_pkg::*;
#(
  parameter int                  DECIM_LOG2 = 8,
  parameter logic [SAMPLE_W-1:0] EAR_HI_THR = EAR_HI_THR_DEFAULT,
  parameter logic [SAMPLE_W-1:0] EAR_LO_THR = EAR_LO_THR_DEFAULT
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                ADCin,
  output logic                ADCfb,
  output logic [SAMPLE_W-1:0] Sample,
  output logic                SampleValid,
  output logic                Ear
);
  localparam int ACC_W = DECIM_LOG2 + 1;

  // A full window of ones overflows the 8-bit field; clamp it to full scale.
  function automatic logic [SAMPLE_W-1:0] sat_sample(input logic [ACC_W-1:0] total);
    if (total[DECIM_LOG2]) return {SAMPLE_W{1'b1}};
    return total[DECIM_LOG2-1 -: SAMPLE_W];
  endfunction

  logic                  s2;
  logic [DECIM_LOG2-1:0] wc_q, wc_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [ACC_W-1:0]      total;
  logic [SAMPLE_W-1:0]   sample_q, sample_d;
  logic                  valid_q, valid_d;
  logic                  ear_q, ear_d;

  sync_2ff u_sync (
    .Clk   (Clk),
    .Reset (Reset),
    .d     (ADCin),
    .q     (s2)
  );

  // The bit seen on the last window cycle is folded into that window's total.
  always_comb begin
    wc_d     = wc_q + DECIM_LOG2'(1);
    total    = acc_q + ACC_W'(s2);
    acc_d    = total;
    sample_d = sample_q;
    valid_d  = 1'b0;
    ear_d    = ear_q;
    if (wc_q == '1) begin
      acc_d    = '0;
      sample_d = sat_sample(total);
      valid_d  = 1'b1;
      if (sample_d >= EAR_HI_THR)      ear_d = 1'b1;
      else if (sample_d <= EAR_LO_THR) ear_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      wc_q     <= '0;
      acc_q    <= '0;
      sample_q <= SAMPLE_MID;
      valid_q  <= 1'b0;
      ear_q    <= 1'b0;
    end else begin
      wc_q     <= wc_d;
      acc_q    <= acc_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
      ear_q    <= ear_d;
    end
  end

  assign ADCfb       = s2;
  assign Sample      = sample_q;
  assign SampleValid = valid_q;
  assign Ear         = ear_q;
endmodule

// File: tb/tb_sigma_delta_adc.sv
// Directed bench for sigma_delta_adc: window densities with hand-computed
// samples, hysteresis, mid-window reset, feedback latency and a 1024 window.
module tb_sigma_delta_adc;
  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       ADCin = 1'b0;
  logic       ADCfb;
  logic [7:0] Sample;
  logic       SampleValid;
  logic       Ear;

  logic       Reset10 = 1'b1;
  logic       ADCin10 = 1'b0;
  logic       ADCfb10;
  logic [7:0] Sample10;
  logic       SampleValid10;
  logic       Ear10;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  sigma_delta_adc u_dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .ADCin       (ADCin),
    .ADCfb       (ADCfb),
    .Sample      (Sample),
    .SampleValid (SampleValid),
    .Ear         (Ear)
  );

  sigma_delta_adc #(.DECIM_LOG2(10)) u_dut10 (
    .Clk         (Clk),
    .Reset       (Reset10),
    .ADCin       (ADCin10),
    .ADCfb       (ADCfb10),
    .Sample      (Sample10),
    .SampleValid (SampleValid10),
    .Ear         (Ear10)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Drive one input bit for one cycle and land #1 after the following edge.
  task automatic step(input bit which, input bit a);
    if (which) ADCin10 = a;
    else       ADCin   = a;
    @(posedge Clk);
    #1;
  endtask

  // mode 0: first `ones` cycles high; mode 1: toggle (odd cycles high);
  // mode 2: 75% density (every fourth cycle low). Window-aligned to wc.
  task automatic run_window(input bit which, input int mode, input int ones,
                            input int exp_s, input int exp_e, input string tag);
    int  n;
    int  extra;
    bit  a;
    n = which ? 1024 : 256;
    extra = 0;
    for (int i = 0; i < n; i++) begin
      if (mode == 0)      a = (i < ones);
      else if (mode == 1) a = i[0];
      else                a = ((i % 4) != 3);
      step(which, a);
      if (i < n - 1 && (which ? SampleValid10 : SampleValid)) extra++;
    end
    chk({tag, "_nostrobe"}, extra, 0);
    chk({tag, "_valid"}, which ? SampleValid10 : SampleValid, 1);
    chk({tag, "_sample"}, which ? Sample10 : Sample, exp_s);
    chk({tag, "_ear"}, which ? Ear10 : Ear, exp_e);
  endtask

  initial begin
    int strobes;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_sample", Sample, 128);
    chk("rst_valid", SampleValid, 0);
    chk("rst_ear", Ear, 0);
    chk("rst_fb", ADCfb, 0);
    chk("rst10_sample", Sample10, 128);
    Reset = 1'b0;

    // Synchroniser holds zeros for the first two cycles, so the first
    // all-ones window counts 254; after that a full window saturates.
    run_window(0, 0, 256, 254, 1, "ones_w1");
    run_window(0, 0, 256, 255, 1, "ones_w2");
    // Two ones from the previous window are still in flight.
    run_window(0, 0, 0, 2, 0, "zeros_w1");
    run_window(0, 0, 0, 0, 0, "zeros_w2");
    chk("zeros_fb", ADCfb, 0);
    run_window(0, 1, 0, 127, 0, "tog_w1");
    run_window(0, 1, 0, 128, 0, "tog_w2");
    run_window(0, 0, 0, 1, 0, "flush");

    run_window(0, 0, 150, 150, 1, "hys150");
    run_window(0, 0, 130, 130, 1, "hys130a");
    run_window(0, 0, 120, 120, 1, "hys120");
    run_window(0, 0, 110, 110, 0, "hys110");
    run_window(0, 0, 130, 130, 0, "hys130b");
    run_window(0, 0, 200, 200, 1, "pre_rst");

    // Reset at wc=100 with the input held high.
    for (int i = 0; i < 100; i++) step(0, 1'b1);
    Reset = 1'b1;
    strobes = 0;
    for (int i = 0; i < 300; i++) begin
      step(0, 1'b1);
      if (SampleValid) strobes++;
    end
    chk("midrst_nostrobe", strobes, 0);
    chk("midrst_sample", Sample, 128);
    chk("midrst_ear", Ear, 0);
    chk("midrst_fb", ADCfb, 0);
    Reset = 1'b0;
    run_window(0, 0, 256, 254, 1, "post_rst");

    // Single-cycle pulse on ADCin reaches ADCfb after exactly two edges.
    for (int i = 0; i < 3; i++) step(0, 1'b0);
    step(0, 1'b1);
    chk("lat_edge1", ADCfb, 0);
    step(0, 1'b0);
    chk("lat_edge2", ADCfb, 1);
    step(0, 1'b0);
    chk("lat_edge3", ADCfb, 0);
    chk("hold_sample", Sample, 254);
    chk("hold_valid", SampleValid, 0);

    // DECIM_LOG2=10, 75% density: first window 767/4 -> 191, then 768/4 -> 192.
    Reset10 = 1'b0;
    run_window(1, 2, 0, 191, 1, "d10_w1");
    run_window(1, 2, 0, 192, 1, "d10_w2");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
